// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer: default sizing and the capture FSM encoding.
package uart_pkg;
  localparam int DEPTH_DEFAULT   = 16;
  localparam int RECOVER_DEFAULT = 4;

  localparam logic [1:0] CAP_IDLE = 2'd0;
  localparam logic [1:0] CAP_ACK  = 2'd1;
  localparam logic [1:0] CAP_WAIT = 2'd2;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the UART-side handshake, the reader-side pop port and the status flags.
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  uart_data_i;
  logic        uart_ready_i;
  logic        uart_error_i;
  logic        uart_ack_o;
  logic        uart_rst_n_o;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [AW:0] count_o;
  logic        overflow_o;
  logic        framing_error_o;
  logic        err_clr_i;

  modport master (
    output uart_data_i, uart_ready_i, uart_error_i, rd_ready_i, err_clr_i,
    input  uart_ack_o, uart_rst_n_o, rd_data_o, rd_valid_o, count_o,
           overflow_o, framing_error_o
  );

  modport slave (
    input  uart_data_i, uart_ready_i, uart_error_i, rd_ready_i, err_clr_i,
    output uart_ack_o, uart_rst_n_o, rd_data_o, rd_valid_o, count_o,
           overflow_o, framing_error_o
  );
endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// DEPTH x 8 show-ahead FIFO; a push at full is accepted when a pop happens in the same cycle.
module byte_fifo import uart_pkg::*; #(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [7:0]  wdata_i,
  input  logic        pop_i,
  output logic [7:0]  rdata_o,
  output logic [AW:0] count_o
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is left out of reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata_o = mem[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// Captures octets from the UART receiver into a FIFO and pulses a recovery reset on receiver errors.
module uart_rx_fifo import uart_pkg::*; #(
  parameter  int DEPTH          = DEPTH_DEFAULT,
  parameter  int RECOVER_CYCLES = RECOVER_DEFAULT,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  logic [1:0]    state_q, state_d;
  logic          ack_q, ack_d;
  logic          rst_n_q, rst_n_d;
  logic          guard_q, guard_d;
  logic [RW-1:0] rec_cnt_q, rec_cnt_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic [AW:0]   count;
  logic          pop, space, err_trig, cap_en, cap_evt, push;

  always_comb begin
    pop      = bus.rd_ready_i && (count != '0);
    space    = (count != (AW+1)'(DEPTH)) || pop;
    err_trig = bus.uart_error_i && rst_n_q && !guard_q;
    // An error edge already counts as recovery so no ack escapes alongside the UART reset.
    cap_en   = rst_n_q && !err_trig;
    cap_evt  = cap_en && (state_q == CAP_IDLE) && bus.uart_ready_i;
    push     = cap_evt && space;

    state_d = state_q;
    ack_d   = 1'b0;
    if (!cap_en) begin
      state_d = CAP_IDLE;
    end else begin
      case (state_q)
        CAP_IDLE: if (bus.uart_ready_i) begin
          state_d = CAP_ACK;
          ack_d   = 1'b1;
        end
        CAP_ACK:  state_d = CAP_WAIT;
        CAP_WAIT: if (!bus.uart_ready_i) state_d = CAP_IDLE;
        default:  state_d = CAP_IDLE;
      endcase
    end

    // rec_cnt counts remaining low cycles; zero at reset gives release on the first edge.
    rst_n_d   = rst_n_q;
    rec_cnt_d = rec_cnt_q;
    guard_d   = 1'b0;
    if (err_trig) begin
      rst_n_d   = 1'b0;
      rec_cnt_d = RW'(RECOVER_CYCLES - 1);
    end else if (!rst_n_q) begin
      if (rec_cnt_q == '0) begin
        rst_n_d = 1'b1;
        guard_d = 1'b1;
      end else begin
        rec_cnt_d = rec_cnt_q - RW'(1);
      end
    end

    ovf_d  = (cap_evt && !space) ? 1'b1 : (bus.err_clr_i ? 1'b0 : ovf_q);
    ferr_d = err_trig ? 1'b1 : (bus.err_clr_i ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CAP_IDLE;
      ack_q     <= 1'b0;
      rst_n_q   <= 1'b0;
      guard_q   <= 1'b0;
      rec_cnt_q <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rst_n_q   <= rst_n_d;
      guard_q   <= guard_d;
      rec_cnt_q <= rec_cnt_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (bus.uart_data_i),
    .pop_i   (pop),
    .rdata_o (bus.rd_data_o),
    .count_o (count)
  );

  assign bus.uart_ack_o      = ack_q;
  assign bus.uart_rst_n_o    = rst_n_q;
  assign bus.rd_valid_o      = (count != '0);
  assign bus.count_o         = count;
  assign bus.overflow_o      = ovf_q;
  assign bus.framing_error_o = ferr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a per-cycle vector table plus hand sequences for wrap, overflow, recovery and reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int RECOVER = 4;

  typedef struct {
    logic [7:0] data;
    logic       rdy, err, rdr, clr;
    logic       ack, rstn, valid;
    logic [7:0] rdata;
    logic [4:0] count;
    logic       ov, fe;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [13];
  byte  q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic rdy, input logic err,
                       input logic rdr, input logic clr);
    bus.uart_data_i  = d;
    bus.uart_ready_i = rdy;
    bus.uart_error_i = err;
    bus.rd_ready_i   = rdr;
    bus.err_clr_i    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [7:0] d, input logic rdy, input logic rdr,
                               input logic ack, input logic valid,
                               input logic [7:0] rdata, input logic [4:0] count);
    vec_t v;
    v.data = d;  v.rdy = rdy; v.err = 1'b0; v.rdr = rdr; v.clr = 1'b0;
    v.ack = ack; v.rstn = 1'b1; v.valid = valid; v.rdata = rdata;
    v.count = count; v.ov = 1'b0; v.fe = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // inputs: data rdy rdr | expected after edge: ack valid rdata count
    vecs[0]  = mkv(8'h41, 1, 0, 1, 1, 8'h41, 5'd1);  // basic capture
    vecs[1]  = mkv(8'h00, 0, 0, 0, 1, 8'h41, 5'd1);
    vecs[2]  = mkv(8'h00, 0, 0, 0, 1, 8'h41, 5'd1);
    vecs[3]  = mkv(8'h00, 0, 1, 0, 0, 8'h00, 5'd0);  // pop
    vecs[4]  = mkv(8'h42, 1, 0, 1, 1, 8'h42, 5'd1);  // ready held 5 cycles
    vecs[5]  = mkv(8'h42, 1, 0, 0, 1, 8'h42, 5'd1);
    vecs[6]  = mkv(8'h42, 1, 0, 0, 1, 8'h42, 5'd1);
    vecs[7]  = mkv(8'h42, 1, 0, 0, 1, 8'h42, 5'd1);
    vecs[8]  = mkv(8'h42, 1, 0, 0, 1, 8'h42, 5'd1);
    vecs[9]  = mkv(8'h43, 0, 0, 0, 1, 8'h42, 5'd1);
    vecs[10] = mkv(8'h43, 1, 0, 1, 1, 8'h42, 5'd2);
    vecs[11] = mkv(8'h00, 0, 1, 0, 1, 8'h43, 5'd1);
    vecs[12] = mkv(8'h00, 0, 1, 0, 0, 8'h00, 5'd0);

    drive(8'h00, 0, 0, 0, 0);
    #1;
    chk("rst_ack",   bus.uart_ack_o, 0);
    chk("rst_uart",  bus.uart_rst_n_o, 0);
    chk("rst_valid", bus.rd_valid_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_ovf",   bus.overflow_o, 0);
    chk("rst_ferr",  bus.framing_error_o, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("release_uart", bus.uart_rst_n_o, 1);

    $display("table: %0d vectors", $size(vecs));
    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].rdy, vecs[i].err, vecs[i].rdr, vecs[i].clr);
      tick();
      chk($sformatf("v%0d_ack", i),   bus.uart_ack_o, vecs[i].ack);
      chk($sformatf("v%0d_rstn", i),  bus.uart_rst_n_o, vecs[i].rstn);
      chk($sformatf("v%0d_valid", i), bus.rd_valid_o, vecs[i].valid);
      if (vecs[i].valid) chk($sformatf("v%0d_rdata", i), bus.rd_data_o, vecs[i].rdata);
      chk($sformatf("v%0d_count", i), bus.count_o, vecs[i].count);
      chk($sformatf("v%0d_ovf", i),   bus.overflow_o, vecs[i].ov);
      chk($sformatf("v%0d_ferr", i),  bus.framing_error_o, vecs[i].fe);
      $display("vec %0d: ack=%0b valid=%0b data=%02h count=%0d", i,
               bus.uart_ack_o, bus.rd_valid_o, bus.rd_data_o, bus.count_o);
    end

    $display("seq: ordering and wrap, 32 octets");
    for (int i = 0; i < 32; i++) begin
      for (int c = 0; c < 3; c++) begin
        logic rdy, rdr;
        rdy = (c == 0);
        rdr = (c == 0) && (i >= 8);
        drive(8'(i), rdy, 0, rdr, 0);
        if (rdr) begin
          chk("order_data", bus.rd_data_o, 32'(q[0]));
          void'(q.pop_front());
        end
        if (rdy) q.push_back(byte'(i));
        tick();
        chk("order_count", bus.count_o, q.size());
      end
    end
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      drive(8'h00, 0, 0, 1, 0);
      chk("drain_data", bus.rd_data_o, 32'(q[0]));
      void'(q.pop_front());
      tick();
      chk("drain_count", bus.count_o, q.size());
    end
    chk("order_ovf", bus.overflow_o, 0);

    $display("seq: overflow at full");
    for (int i = 0; i < DEPTH; i++) begin
      drive(8'(8'h80 + i), 1, 0, 0, 0);
      tick();
      drive(8'h00, 0, 0, 0, 0);
      tick();
      tick();
    end
    chk("full_count", bus.count_o, 16);
    drive(8'hAA, 1, 0, 0, 0);
    tick();
    chk("drop_ack",   bus.uart_ack_o, 1);
    chk("drop_count", bus.count_o, 16);
    chk("drop_ovf",   bus.overflow_o, 1);
    chk("drop_head",  bus.rd_data_o, 8'h80);
    drive(8'h00, 0, 0, 0, 0);
    tick();
    tick();
    drive(8'h00, 0, 0, 0, 1);
    tick();
    chk("ovf_clr", bus.overflow_o, 0);
    drive(8'hBB, 1, 0, 1, 0);
    tick();
    chk("fullpop_ack",   bus.uart_ack_o, 1);
    chk("fullpop_count", bus.count_o, 16);
    chk("fullpop_ovf",   bus.overflow_o, 0);
    chk("fullpop_head",  bus.rd_data_o, 8'h81);
    drive(8'h00, 0, 0, 0, 0);
    tick();
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      drive(8'h00, 0, 0, 1, 0);
      chk("full_drain", bus.rd_data_o, (k < 15) ? 32'(8'h81 + k) : 32'h0BB);
      tick();
    end
    chk("full_drain_count", bus.count_o, 0);

    $display("seq: error recovery");
    drive(8'h55, 1, 0, 0, 0);
    tick();
    drive(8'h00, 0, 0, 0, 0);
    tick();
    tick();
    drive(8'h00, 0, 1, 0, 0);
    tick();
    chk("err_ferr", bus.framing_error_o, 1);
    chk("err_uart", bus.uart_rst_n_o, 0);
    chk("err_ack",  bus.uart_ack_o, 0);
    begin
      int low;
      low = 1;
      for (int j = 0; j < 10; j++) begin
        drive(8'h00, 0, (j < 3), 0, 0);
        tick();
        if (bus.uart_rst_n_o == 1'b0) low++;
      end
      chk("err_low_cycles", low, RECOVER);
    end
    chk("err_uart_back", bus.uart_rst_n_o, 1);
    chk("err_count",     bus.count_o, 1);
    chk("err_head",      bus.rd_data_o, 8'h55);
    drive(8'h00, 0, 0, 0, 1);
    tick();
    chk("ferr_clr", bus.framing_error_o, 0);
    drive(8'h00, 0, 1, 0, 1);
    tick();
    chk("ferr_set_wins", bus.framing_error_o, 1);
    chk("ferr_set_uart", bus.uart_rst_n_o, 0);
    drive(8'h00, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) tick();
    chk("ferr_sticky", bus.framing_error_o, 1);
    chk("ferr_uart_back", bus.uart_rst_n_o, 1);

    $display("seq: reset during ack");
    drive(8'h66, 1, 0, 0, 0);
    tick();
    chk("midack_ack",   bus.uart_ack_o, 1);
    chk("midack_count", bus.count_o, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_ack",   bus.uart_ack_o, 0);
    chk("async_uart",  bus.uart_rst_n_o, 0);
    chk("async_count", bus.count_o, 0);
    chk("async_valid", bus.rd_valid_o, 0);
    chk("async_ferr",  bus.framing_error_o, 0);
    drive(8'h00, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rerelease_uart",  bus.uart_rst_n_o, 1);
    chk("rerelease_count", bus.count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the UART receiver half. Captures each completed octet (data/ready), acknowledges it and buffers it in a small FIFO for the CPU keyboard/reader path.
- Also supervises receiver errors. A receiver error is only cleared by its reset, so this block flags the error and pulses a recovery reset to the receiver.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived, not overridden)
RECOVER_CYCLES, 4, cycles uart_rst_n_o is held low after a receiver error; >= 1

Ports:
clk  in  1  system clock; all transitions on posedge
reset  in  1  asynchronous, active-low reset
uart_data_i  in  8  received octet from UART; valid while uart_ready_i
uart_ready_i  in  1  UART holds a complete octet
uart_error_i  in  1  UART is in error state
uart_ack_o  out  1  registered one-cycle acknowledge to UART
uart_rst_n_o  out  1  registered active-low reset to UART receiver
rd_data_o  out  8  head-of-FIFO octet (show-ahead), valid while rd_valid_o
rd_valid_o  out  1  FIFO not empty
rd_ready_i  in  1  consumer pops head when rd_valid_o && rd_ready_i
count_o  out  AW+1  current occupancy, 0..DEPTH
overflow_o  out  1  sticky: an octet was dropped because FIFO was full
framing_error_o  out  1  sticky: UART error observed
err_clr_i  in  1  clears both sticky flags

Behaviour:
- Reset values (asynchronous, reset low):
  - uart_ack_o=0, uart_rst_n_o=0, rd_valid_o=0, count_o=0, overflow_o=0, framing_error_o=0.
  - Pointers are 0 and FSM=CAP_IDLE.
  - FIFO storage is not reset. rd_data_o is don't-care while rd_valid_o=0.
- After reset is released, uart_rst_n_o goes 1 on the first clk edge.
- Capture FSM has three states: CAP_IDLE, CAP_ACK, CAP_WAIT.
  - CAP_IDLE, uart_ready_i=1 at edge N:
    - If space is available, write uart_data_i at edge N. Space is available when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
    - Otherwise drop the octet and set overflow_o.
    - In both cases uart_ack_o=1 for the cycle after edge N, and state goes to CAP_ACK.
  - CAP_ACK: uart_ack_o returns to 0 at the next edge and state goes to CAP_WAIT.
  - CAP_WAIT: return to CAP_IDLE on the first edge with uart_ready_i=0. This guarantees no double capture of one octet.
- Dropping on full (rather than withholding the ack) is deliberate. The UART escalates an unacknowledged full state into a fatal error when the next start bit arrives.
- Capture latency: octet present at edge N means rd_valid_o=1 and count_o updated in cycle N+1 (when the FIFO was empty).
- Read side:
  - rd_data_o = mem[rptr], combinational from registers; rd_valid_o = (count != 0).
  - A pop advances rptr at the edge.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Error supervisor, uart_error_i=1 while uart_rst_n_o=1 at an edge:
  - Set framing_error_o.
  - Drive uart_rst_n_o=0 for exactly RECOVER_CYCLES cycles, then 1.
  - uart_error_i is ignored while uart_rst_n_o=0 and for 1 cycle after release.
  - The capture FSM is forced to CAP_IDLE while uart_rst_n_o=0, and uart_ack_o=0.
  - FIFO contents are preserved.
- Sticky flags: err_clr_i clears overflow_o and framing_error_o. A set event in the same cycle takes priority and the flag stays 1.
- Reset asserted mid-operation (e.g. during CAP_ACK): everything returns to reset values immediately. The UART is reset with it.

Decomposition:
- Shared package uart_pkg:
  - Capture state localparams CAP_IDLE=2'd0, CAP_ACK=2'd1, CAP_WAIT=2'd2.
  - Default DEPTH and RECOVER_CYCLES.
- One sub-module: byte_fifo (DEPTH x 8 storage, pointers, count, show-ahead read, push/pop with push-when-full-and-pop allowed).
- The capture FSM and error supervisor live in uart_rx_fifo.

Test Plan:
- Basic capture: present 0x41 with uart_ready_i for one capture, then drop ready the cycle after ack → exactly one uart_ack_o pulse, rd_valid_o=1, rd_data_o=0x41, count_o=1 next cycle; pop → count_o=0.
- Ordering/wrap: push 0x00..0x1F (32 octets, DEPTH=16) interleaved with pops → read sequence 0x00..0x1F in order, count_o never exceeds 16, overflow_o stays 0.
- Overflow: fill 16 without popping, present 0xAA → ack still pulses, count_o=16, overflow_o=1, head unchanged. Present 0xBB in the same cycle as a pop at full → 0xBB accepted, overflow_o not newly set.
- Hold-off: uart_ready_i held high 5 cycles → exactly one write and one ack.
- Error recovery: assert uart_error_i → framing_error_o=1, uart_rst_n_o low exactly 4 cycles, FIFO count unchanged. Pulse err_clr_i → flag 0. Pulse err_clr_i together with a new error → flag stays 1.
- Reset mid-ACK: assert reset while uart_ack_o=1 → uart_ack_o=0, uart_rst_n_o=0, count_o=0 asynchronously. Release → uart_rst_n_o=1 after the first edge.
